sync_rr_arbiter: RTL
====================

Name: sync_rr_arbiter

Overview:
Clocked round-robin arbiter sharing one router output port (e.g. the processor output) between N_IN four-phase req/ack requesters. It is the synchronous counterpart of the click-based four-input arbiter, used on router variants with a system clock. The arbiter:
- captures the winning requester's flit;
- drives it on the shared output with a four-phase handshake;
- returns the ack to the winner only after the output handshake completes;
- watches for a stalled consumer.

Parameters:
n, 32, flit data width in bits
N_IN, 4, number of requesters (2..8)
TIMEOUT, 1024, cycles a handshake may stay open before timeout_err is set (>=2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous active-low reset
in_req  input  N_IN  per-requester four-phase request; synchronous to clk (synchronisers are outside this block)
in_ack  output  N_IN  per-requester acknowledge
in_data  input  N_IN*n  flits; requester i occupies bits [i*n +: n]
out_req  output  1  shared-port request
out_ack  input  1  shared-port acknowledge; synchronous to clk
out_data  output  n  registered flit for the current grant
grant  output  N_IN  one-hot current owner; all zero when idle
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky stall flag

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: in_ack=0, out_req=0, out_data=0, grant=0, busy=0, timeout_err=0.
  - State: state=IDLE, last pointer=N_IN-1 (so requester 0 wins first), timeout counter=0.
  - Reset mid-handshake abandons the transfer silently; the requester must re-present after reset.
- Outputs are registered; all of them change only on rising clk edges.
- States:
  - IDLE -> GRANT: on an edge where any in_req is 1.
    - Winner = first requester with in_req=1 when scanning last+1, last+2, ... modulo N_IN.
    - At that same edge: out_data <= winner flit, grant <= onehot(winner), out_req <= 1, last <= winner.
    - Latency: in_req high at edge t gives out_req high after edge t.
  - GRANT -> RTZ: on an edge where out_ack=1.
    - At that edge: out_req <= 0, in_ack[winner] <= 1.
  - RTZ -> IDLE: on the first edge where out_ack=0 AND in_req[winner]=0, in either order or simultaneously.
    - At that edge: in_ack[winner] <= 0, grant <= 0.
    - New arbitration is possible on the next edge; minimum 3 cycles per flit.
- Data stability:
  - out_data is held constant from GRANT entry until the next grant.
  - in_data of the winner is sampled once, at the grant edge only.
- Fairness: requesters other than the winner are ignored while busy. With all N_IN requesting continuously, grants rotate 0,1,...,N_IN-1,0,...
- Protocol violations:
  - Winner drops in_req while in GRANT: the transfer completes normally.
  - in_ack is never asserted to a non-granted requester.
  - out_ack=1 while in IDLE is ignored.
- Timeout:
  - The counter clears on entry to GRANT and increments each cycle spent in GRANT or RTZ.
  - When it reaches TIMEOUT-1, timeout_err <= 1 (sticky until reset). The transfer is not aborted.
  - The counter saturates at TIMEOUT-1 and is sized $clog2(TIMEOUT).
- Simultaneous events: a request arriving on the same edge as the RTZ->IDLE exit is not seen until the following edge; no grant is issued from RTZ.

Decomposition:
- router_pkg additions:
  - arb_state_t enum {IDLE, GRANT, RTZ};
  - localparam NUM_ARB_PORTS=4;
  - function onehot(idx).
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector and last pointer.
  - Outputs: valid, winner index.
  - Rotate-then-priority-encode.
  - Instantiated once.

Test Plan:
- Reset then single request: in_req=4'b0100, in_data[2]=32'hA5A5_0002, drive out_ack one cycle after out_req and drop in_req after in_ack -> out_data=32'hA5A5_0002, grant=4'b0100, out_req high one cycle after the request edge, in_ack[2] pulses, returns to IDLE.
- All four requesting continuously, consumer acks after 1 cycle -> grant order 0,1,2,3,0,1; each flit matches its source; exactly one in_ack bit high at any time.
- Requesters 1 and 3 only, with last pointer at 1 -> 3 wins before 1; then alternation 1,3,1,3.
- out_ack held 0 with TIMEOUT=16 -> timeout_err rises exactly 15 cycles after GRANT entry and stays high after the handshake later completes; cleared only by rst=0.
- Asynchronous reset asserted in RTZ with in_ack[1]=1 -> all outputs 0 immediately, without waiting for a clk edge; after release, a request on 0 wins first.
- Order-of-return checks in RTZ:
  - Winner drops in_req before out_ack falls -> in_ack stays 1 until out_ack=0.
  - Both fall on the same edge -> IDLE on that edge.
  - Winner drops in_req during GRANT -> the flit is still delivered.

Source files
------------

// File: rtl/sync_rr_arbiter_pkg.sv
// Shared types and helpers for the clocked round-robin output arbiter.
// Arbitration state, default port count and grant one-hot encoding.
package sync_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RTZ   = 2'd2
   } arb_state_t;

   localparam int NUM_ARB_PORTS = 4;
   localparam int MAX_ARB_PORTS = 8;

   // Result is widest-case; callers size-cast down to their port count.
   function automatic logic [MAX_ARB_PORTS-1:0] onehot(input int unsigned idx);
      logic [MAX_ARB_PORTS-1:0] v;
      v = '0;
      v[idx[2:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sync_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot
// after the last winner sits at bit 0, then take the lowest set bit.
module sync_rr_arbiter_rr_pick
   import sync_rr_arbiter_pkg::*;
#(
   parameter int N_IN = NUM_ARB_PORTS,
   parameter int IW   = $clog2(N_IN)
) (
   input  logic [N_IN-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   winner
);

   logic [2*N_IN-1:0] dbl;
   logic [N_IN-1:0]   rot;
   int                base;
   int                k;

   always_comb begin
      dbl  = {req, req};
      base = int'(last) + 1;
      rot  = dbl[base +: N_IN];
      k    = 0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (rot[i]) k = i;
      end
      valid  = |req;
      winner = IW'((base + k) % N_IN);
   end

endmodule

// File: rtl/sync_rr_arbiter.sv
// Clocked round-robin arbiter sharing one four-phase output port between
// N_IN four-phase requesters; ack goes back only after the output handshake.
module sync_rr_arbiter
   import sync_rr_arbiter_pkg::*;
#(
   parameter int n       = 32,
   parameter int N_IN    = NUM_ARB_PORTS,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IN-1:0]   in_req,
   output logic [N_IN-1:0]   in_ack,
   input  logic [N_IN*n-1:0] in_data,
   output logic              out_req,
   input  logic              out_ack,
   output logic [n-1:0]      out_data,
   output logic [N_IN-1:0]   grant,
   output logic              busy,
   output logic              timeout_err
);

   localparam int IW = $clog2(N_IN);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   arb_state_t      state;
   logic [IW-1:0]   last;
   logic [IW-1:0]   pick_idx;
   logic            pick_valid;
   logic [CW-1:0]   cnt;
   logic            owner_req;

   sync_rr_arbiter_rr_pick #(.N_IN(N_IN), .IW(IW)) u_pick (
      .req    (in_req),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_idx)
   );

   // grant is one-hot, so this is the current owner's request line.
   assign owner_req = |(in_req & grant);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last     <= IW'(N_IN - 1);
         in_ack   <= '0;
         out_req  <= 1'b0;
         out_data <= '0;
         grant    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= GRANT;
                  out_data <= in_data[int'(pick_idx)*n +: n];
                  grant    <= N_IN'(onehot(32'(pick_idx)));
                  out_req  <= 1'b1;
                  last     <= pick_idx;
               end
            end
            GRANT: begin
               if (out_ack) begin
                  state   <= RTZ;
                  out_req <= 1'b0;
                  in_ack  <= grant;
               end
            end
            RTZ: begin
               // Both sides must have returned to zero, in any order.
               if (!out_ack && !owner_req) begin
                  state  <= IDLE;
                  in_ack <= '0;
                  grant  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stall watchdog: counts cycles with a handshake open, flag is sticky.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else if (state == IDLE) begin
         cnt <= '0;
      end else begin
         if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
         if (cnt == CNT_MAX - 1'b1) timeout_err <= 1'b1;
      end
   end

endmodule
